// File: rtl/fft_io.sv
// fft_io: loads 64 samples transposed into the FFT matrix, starts compute, then streams results out in order
module fft_io #(
  parameter int DATA_WD      = 10,
  parameter bit IN_TRANSPOSE = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_vld_i,
  output logic               in_rdy_o,
  input  logic [DATA_WD-1:0] in_dat_i,
  output logic               fft_start_o,
  input  logic               fft_done_i,
  output logic               out_vld_o,
  input  logic               out_rdy_i,
  output logic [DATA_WD-1:0] out_dat_o,
  output logic               out_lst_o,
  output logic               busy_o,
  output logic [5:0]         adr_1x1_o,
  output logic               wr_vld_1x1_o,
  output logic [DATA_WD-1:0] wr_dat_1x1_o,
  output logic               rd_vld_1x1_o,
  input  logic               rd_vld_1x1_i,
  input  logic [DATA_WD-1:0] rd_dat_1x1_i
);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, UNLOAD, DRAIN} state_t;
  state_t state_q, state_d;
  logic [5:0] ld_cnt_q, ld_cnt_d, rd_cnt_q, rd_cnt_d, out_cnt_q, out_cnt_d;
  logic start_q, start_d, inflt_q, hd_q, hd_d;
  logic [1:0] cnt_q, cnt_d;
  logic [DATA_WD-1:0] buf_q [2];
  logic acc, rd, pop, push;
  logic [2:0] occ;
  logic [5:0] ld_adr;

  assign in_rdy_o     = (state_q == IDLE) || (state_q == LOAD);
  assign acc          = in_vld_i & in_rdy_o;
  assign ld_adr       = IN_TRANSPOSE ? {ld_cnt_q[2:0], ld_cnt_q[5:3]} : ld_cnt_q;
  assign out_vld_o    = cnt_q != 2'd0;
  assign pop          = out_vld_o & out_rdy_i;
  assign push         = rd_vld_1x1_i & inflt_q;
  // results held plus the one in flight, minus the slot freed by this cycle's pop
  assign occ          = {1'b0, cnt_q} + {2'b0, inflt_q} - {2'b0, pop};
  assign rd           = (state_q == UNLOAD) && (occ < 3'd2);
  assign wr_vld_1x1_o = acc;
  assign wr_dat_1x1_o = acc ? in_dat_i : '0;
  assign rd_vld_1x1_o = rd;
  assign adr_1x1_o    = acc ? ld_adr : (rd ? rd_cnt_q : 6'd0);
  assign out_dat_o    = out_vld_o ? buf_q[hd_q] : '0;
  assign out_lst_o    = out_vld_o && (out_cnt_q == 6'd63);
  assign busy_o       = state_q != IDLE;
  assign fft_start_o  = start_q;

  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    ld_cnt_d  = acc ? ld_cnt_q + 6'd1 : ld_cnt_q;
    rd_cnt_d  = rd ? rd_cnt_q + 6'd1 : rd_cnt_q;
    out_cnt_d = pop ? out_cnt_q + 6'd1 : out_cnt_q;
    cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};
    hd_d      = hd_q ^ pop;
    case (state_q)
      IDLE:    state_d = acc ? LOAD : IDLE;
      LOAD:    if (acc && ld_cnt_q == 6'd63) begin
                 state_d = WAIT;
                 start_d = 1'b1;
               end
      WAIT:    state_d = fft_done_i ? UNLOAD : WAIT;
      UNLOAD:  state_d = (rd && rd_cnt_q == 6'd63) ? DRAIN : UNLOAD;
      DRAIN:   state_d = (pop && out_cnt_q == 6'd63) ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      ld_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      out_cnt_q <= '0;
      inflt_q   <= 1'b0;
      hd_q      <= 1'b0;
      cnt_q     <= '0;
      buf_q[0]  <= '0;
      buf_q[1]  <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      ld_cnt_q  <= ld_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      out_cnt_q <= out_cnt_d;
      inflt_q   <= rd;
      hd_q      <= hd_d;
      cnt_q     <= cnt_d;
      if (push) buf_q[hd_q ^ cnt_q[0]] <= rd_dat_1x1_i;
    end
  end
endmodule
